// File: rtl/exibe_resultado_if.sv
// Result bus between the sign-magnitude add/sub unit and the display stage.
// The master side is the upstream producer. The slave side is exibe_resultado.
interface exibe_resultado_if;
  logic       valid;
  logic       sres;
  logic [4:0] res;
  logic       ready;
  logic       done;
  logic       neg;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;
  logic [6:0] seg;
  logic [2:0] an;

  modport master (
    output valid, sres, res,
    input  ready, done, neg, bcd_tens, bcd_units, seg, an
  );

  modport slave (
    input  valid, sres, res,
    output ready, done, neg, bcd_tens, bcd_units, seg, an
  );
endinterface

// File: rtl/exibe_resultado.sv
// Result display stage.
// Captures a sign/magnitude result and converts the magnitude to BCD with a
// 5-step shift-add-3 engine. It then scans sign, tens and units onto a
// multiplexed 3-digit 7-segment display.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | nothing converted since reset, ready for a result
// S_CONV | double-dabble running, one iteration per clock, valid ignored
// S_SHOW | result on display, ready for the next result
module exibe_resultado #(
  parameter int unsigned REFRESH_DIV    = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  exibe_resultado_if.slave bus
);

  localparam int unsigned      CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]       AN_OFF   = DIG_ACTIVE_LOW ? 3'b111 : 3'b000;
  localparam logic [6:0]       GLYPH_MINUS = 7'b1000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  state_t     state;
  logic       ready_q;
  logic       done_q;
  logic       neg_q;
  logic       have_q;
  logic       sgn_q;
  logic [3:0] tens_q;
  logic [3:0] units_q;
  logic [4:0] mag_q;
  logic [7:0] bcd_q;
  logic [2:0] iter_q;

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [6:0]       seg_q;
  logic [2:0]       an_q;

  // Active-high glyph for one decimal digit. Codes above 9 are shown blank.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b0111111;
      4'd1:    g = 7'b0000110;
      4'd2:    g = 7'b1011011;
      4'd3:    g = 7'b1001111;
      4'd4:    g = 7'b1100110;
      4'd5:    g = 7'b1101101;
      4'd6:    g = 7'b1111101;
      4'd7:    g = 7'b0000111;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1101111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // One double-dabble iteration: add 3 to any nibble of 5 or more, then shift.
  // For a 5-bit input the tens nibble never goes above 3. Only its low three
  // bits therefore survive the shift.
  logic [2:0] adj_tens;
  logic [3:0] adj_units;
  logic [7:0] bcd_nx;
  logic [4:0] mag_nx;
  logic       conv_last;

  always_comb begin
    adj_tens  = (bcd_q[7:4] >= 4'd5) ? (bcd_q[6:4] + 3'd3) : bcd_q[6:4];
    adj_units = (bcd_q[3:0] >= 4'd5) ? (bcd_q[3:0] + 4'd3) : bcd_q[3:0];
    bcd_nx    = {adj_tens, adj_units, mag_q[4]};
    mag_nx    = {mag_q[3:0], 1'b0};
    conv_last = (state == S_CONV) && (iter_q == 3'd4);
  end

  // Control FSM: accept a result, run five conversion steps, publish outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      have_q  <= 1'b0;
      sgn_q   <= 1'b0;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      mag_q   <= 5'd0;
      bcd_q   <= 8'd0;
      iter_q  <= 3'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_SHOW: begin
          if (bus.valid) begin
            mag_q   <= bus.res;
            // A negative zero is displayed as a plain zero.
            sgn_q   <= bus.sres & (|bus.res);
            bcd_q   <= 8'd0;
            iter_q  <= 3'd0;
            ready_q <= 1'b0;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_q  <= bcd_nx;
          mag_q  <= mag_nx;
          iter_q <= iter_q + 3'd1;
          if (conv_last) begin
            tens_q  <= bcd_nx[7:4];
            units_q <= bcd_nx[3:0];
            neg_q   <= sgn_q;
            have_q  <= 1'b1;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state   <= S_SHOW;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // These are the values the FSM registers will hold after this edge.
  // The display therefore switches on the same edge as the data.
  logic       have_d;
  logic       neg_d;
  logic [3:0] tens_d;
  logic [3:0] units_d;
  logic       wrap;
  logic [1:0] idx_nx;
  logic [6:0] raw_seg;
  logic [2:0] raw_an;
  logic [6:0] seg_d;
  logic [2:0] an_d;

  // Next digit index and the segment and enable pattern for that digit.
  always_comb begin
    have_d  = have_q | conv_last;
    neg_d   = conv_last ? sgn_q       : neg_q;
    tens_d  = conv_last ? bcd_nx[7:4] : tens_q;
    units_d = conv_last ? bcd_nx[3:0] : units_q;

    wrap   = (cnt_q == CNT_LAST);
    idx_nx = idx_q;
    if (wrap) begin
      idx_nx = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end

    raw_seg = 7'b0000000;
    raw_an  = 3'b000;
    if (have_d) begin
      case (idx_nx)
        2'd0: begin
          raw_seg = glyph(units_d);
          raw_an  = 3'b001;
        end
        2'd1: begin
          raw_seg = (tens_d == 4'd0) ? 7'b0000000 : glyph(tens_d);
          raw_an  = 3'b010;
        end
        default: begin
          raw_seg = neg_d ? GLYPH_MINUS : 7'b0000000;
          raw_an  = 3'b100;
        end
      endcase
    end

    seg_d = SEG_ACTIVE_LOW ? ~raw_seg : raw_seg;
    an_d  = DIG_ACTIVE_LOW ? ~raw_an  : raw_an;
  end

  // Scan timer and registered display drive. This runs in every FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      idx_q <= idx_nx;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.neg       = neg_q;
  assign bus.bcd_tens  = tens_q;
  assign bus.bcd_units = units_q;
  assign bus.seg       = seg_q;
  assign bus.an        = an_q;

endmodule

// File: tb/tb_exibe_resultado.sv
// Self-checking bench for exibe_resultado (REFRESH_DIV=4, active-low display).
module tb_exibe_resultado;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exibe_resultado_if bus();

  exibe_resultado #(
    .REFRESH_DIV    (DIV),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [6:0] glyph_hi [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a countdown of busy cycles and the arithmetic digits.
  int m_left = 0;
  int m_pend = 0;
  bit m_psgn = 0;
  bit m_done = 0, m_neg = 0, m_have = 0;
  int m_tens = 0, m_units = 0;
  int m_n = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 0; m_neg = 0; m_have = 0;
      m_tens = 0; m_units = 0; m_n = 0;
    end else begin
      m_n++;
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_tens  = m_pend / 10;
          m_units = m_pend % 10;
          m_neg   = m_psgn && (m_pend != 0);
          m_have  = 1;
          m_done  = 1;
        end
      end else if (bus.valid) begin
        m_pend = int'(bus.res);
        m_psgn = bus.sres;
        m_left = 5;
      end
    end
  end

  function automatic void exp_disp(output logic [6:0] s, output logic [2:0] a);
    int idx;
    idx = (m_n / DIV) % 3;
    if (!m_have) begin
      s = 7'h7F; a = 3'b111;
    end else if (idx == 0) begin
      s = ~glyph_hi[m_units]; a = 3'b110;
    end else if (idx == 1) begin
      s = (m_tens == 0) ? 7'h7F : ~glyph_hi[m_tens]; a = 3'b101;
    end else begin
      s = m_neg ? 7'b0111111 : 7'h7F; a = 3'b011;
    end
  endfunction

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [6:0] es;
    logic [2:0] ea;
    if (chk_en) begin
      exp_disp(es, ea);
      chk("m_ready", bus.ready, (m_left == 0));
      chk("m_done",  bus.done,  m_done);
      chk("m_neg",   bus.neg,   m_neg);
      chk("m_tens",  bus.bcd_tens,  m_tens);
      chk("m_units", bus.bcd_units, m_units);
      chk("m_seg",   bus.seg, es);
      chk("m_an",    bus.an,  ea);
    end
  end

  typedef struct {
    logic       sres;
    logic [4:0] res;
    int         tens;
    int         units;
    logic       neg;
    logic [6:0] u_seg;
    logic [6:0] t_seg;
    logic [6:0] s_seg;
  } vec_t;

  vec_t vecs[8];

  // Pulse valid for one edge and report the edges from accept to done.
  task automatic convert(input logic s, input logic [4:0] r, output int lat);
    @(negedge clk);
    bus.valid = 1'b1; bus.sres = s; bus.res = r;
    @(negedge clk);
    bus.valid = 1'b0;
    lat = -1;
    for (int k = 0; k <= 12; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, dcnt, start, found;
    logic [2:0] prev;
    logic [2:0] seq [3];
    logic [2:0] seen;

    vecs[0] = '{1'b0, 5'd7,  0, 7, 1'b0, 7'b1111000, 7'b1111111, 7'b1111111};
    vecs[1] = '{1'b1, 5'd30, 3, 0, 1'b1, 7'b1000000, 7'b0110000, 7'b0111111};
    vecs[2] = '{1'b1, 5'd0,  0, 0, 1'b0, 7'b1000000, 7'b1111111, 7'b1111111};
    vecs[3] = '{1'b0, 5'd31, 3, 1, 1'b0, 7'b1111001, 7'b0110000, 7'b1111111};
    vecs[4] = '{1'b1, 5'd9,  0, 9, 1'b1, 7'b0010000, 7'b1111111, 7'b0111111};
    vecs[5] = '{1'b0, 5'd10, 1, 0, 1'b0, 7'b1000000, 7'b1111001, 7'b1111111};
    vecs[6] = '{1'b1, 5'd19, 1, 9, 1'b1, 7'b0010000, 7'b1111001, 7'b0111111};
    vecs[7] = '{1'b0, 5'd0,  0, 0, 1'b0, 7'b1000000, 7'b1111111, 7'b1111111};
    seq[0] = 3'b110; seq[1] = 3'b101; seq[2] = 3'b011;

    rst = 1'b1; bus.valid = 1'b0; bus.sres = 1'b0; bus.res = 5'd0;
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_an", bus.an, 3'b111);
    chk("rst_seg", bus.seg, 7'b1111111);
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_bcd", {bus.bcd_tens, bus.bcd_units}, 8'h00);

    // Table-driven conversions with digit glyph checks over a full scan
    for (int v = 0; v < 8; v++) begin
      convert(vecs[v].sres, vecs[v].res, lat);
      chk("latency", lat, 5);
      chk("tbl_tens", bus.bcd_tens, vecs[v].tens);
      chk("tbl_units", bus.bcd_units, vecs[v].units);
      chk("tbl_neg", bus.neg, vecs[v].neg);
      seen = 3'b000;
      for (int c = 0; c < 3 * DIV + 1; c++) begin
        if (bus.an == 3'b110) begin chk("tbl_useg", bus.seg, vecs[v].u_seg); seen[0] = 1'b1; end
        if (bus.an == 3'b101) begin chk("tbl_tseg", bus.seg, vecs[v].t_seg); seen[1] = 1'b1; end
        if (bus.an == 3'b011) begin chk("tbl_sseg", bus.seg, vecs[v].s_seg); seen[2] = 1'b1; end
        @(negedge clk);
      end
      chk("tbl_scan_seen", seen, 3'b111);
    end

    // valid pulses during CONV carry other data and must be ignored
    @(negedge clk); bus.valid = 1'b1; bus.sres = 1'b0; bus.res = 5'd21;
    @(negedge clk); bus.sres = 1'b1; bus.res = 5'd3;
    @(negedge clk); bus.valid = 1'b0;
    @(negedge clk); bus.valid = 1'b1; bus.res = 5'd14;
    @(negedge clk); bus.valid = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.done) dcnt++;
      @(negedge clk);
    end
    chk("ign_done_cnt", dcnt, 1);
    chk("ign_tens", bus.bcd_tens, 2);
    chk("ign_units", bus.bcd_units, 1);
    chk("ign_neg", bus.neg, 1'b0);

    // valid held high: one conversion every 6 cycles
    @(negedge clk);
    bus.valid = 1'b1; bus.res = 5'($urandom_range(0, 31)); bus.sres = 1'($urandom);
    dcnt = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
      bus.res = 5'($urandom_range(0, 31)); bus.sres = 1'($urandom);
    end
    bus.valid = 1'b0;
    chk("held_done_cnt", dcnt, 4);

    // Randomized traffic with occasional resets, checked by the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      bus.valid = ($urandom_range(0, 2) == 0);
      bus.res = 5'($urandom_range(0, 31));
      bus.sres = 1'($urandom);
    end
    @(negedge clk); rst = 1'b0; bus.valid = 1'b0;
    repeat (8) @(negedge clk);

    // Reset two cycles after an accept aborts the conversion
    bus.valid = 1'b1; bus.sres = 1'b0; bus.res = 5'd12;
    @(negedge clk); bus.valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_an", bus.an, 3'b111);
    chk("abort_seg", bus.seg, 7'b1111111);
    dcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_an_blank", bus.an, 3'b111);

    // Convert 25 and follow the digit scan order
    convert(1'b0, 5'd25, lat);
    chk("s25_latency", lat, 5);
    chk("s25_tens", bus.bcd_tens, 2);
    chk("s25_units", bus.bcd_units, 5);
    prev = bus.an;
    found = 0;
    for (int k = 0; k < 2 * DIV; k++) begin
      @(negedge clk);
      if (bus.an != prev) begin found = 1; break; end
    end
    chk("s25_scan_change", found, 1);
    start = -1;
    for (int s = 0; s < 3; s++) if (seq[s] == bus.an) start = s;
    chk("s25_scan_valid", (start >= 0), 1'b1);
    if (start < 0) start = 0;
    for (int j = 1; j < 12; j++) begin
      @(negedge clk);
      chk("s25_an_seq", bus.an, seq[(start + j / DIV) % 3]);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
